victim_buffer: RTL and testbench

//  N-entry fully associative victim buffer that sits between L1 and L2.

---
 rtl/victim_buffer.sv | 152 +++++++++++++++
 tb/tb_victim_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_buffer.sv
// rtl/victim_buffer.sv - fully associative victim buffer between L1 and L2 with dirty-line writeback
module victim_buffer #(
    parameter int TAG_W   = 12,
    parameter int DATA_W  = 128,
    parameter int ENTRIES = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              lookup_done,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_data,
    output logic              hit_dirty,
    input  logic              insert_valid,
    output logic              insert_ready,
    input  logic [TAG_W-1:0]  insert_tag,
    input  logic [DATA_W-1:0] insert_data,
    input  logic              insert_dirty,
    input  logic              inv_valid,
    input  logic [IDX_W-1:0]  inv_idx,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data
);

    typedef enum logic {IDLE = 1'b0, WB_WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  dirty_q;
    logic [TAG_W-1:0]    tag_q  [ENTRIES];
    logic [DATA_W-1:0]   data_q [ENTRIES];
    logic [IDX_W-1:0]    repl_ptr;

    logic                lk_match;
    logic [IDX_W-1:0]    lk_idx;
    logic                ins_match;
    logic [IDX_W-1:0]    ins_match_idx;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    target;
    logic                use_repl;
    logic                insert_accept;
    logic                start_wb;

    // Parallel tag compare for lookup and insert, plus lowest free slot search
    always_comb begin
        lk_match      = 1'b0;
        lk_idx        = '0;
        ins_match     = 1'b0;
        ins_match_idx = '0;
        free_found    = 1'b0;
        free_idx      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == lookup_tag) begin
                lk_match = 1'b1;
                lk_idx   = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == insert_tag) begin
                ins_match     = 1'b1;
                ins_match_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        use_repl = !ins_match && !free_found;
        if (ins_match)       target = ins_match_idx;
        else if (free_found) target = free_idx;
        else                 target = repl_ptr;
    end

    assign insert_accept = insert_valid && insert_ready;
    // Only a replaced line that is both valid and dirty needs to reach L2
    assign start_wb      = insert_accept && use_repl && valid_q[repl_ptr] && dirty_q[repl_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_wb) state_d = WB_WAIT;
            WB_WAIT: if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        insert_ready = (state_q == IDLE);
        wb_valid     = (state_q == WB_WAIT);
    end

    // Invalidate is applied first so a same-slot insert overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            dirty_q  <= '0;
            repl_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (inv_valid) begin
                valid_q[inv_idx] <= 1'b0;
                dirty_q[inv_idx] <= 1'b0;
            end
            if (insert_accept) begin
                valid_q[target] <= 1'b1;
                tag_q[target]   <= insert_tag;
                data_q[target]  <= insert_data;
                dirty_q[target] <= ins_match ? (dirty_q[target] | insert_dirty) : insert_dirty;
                if (use_repl) repl_ptr <= repl_ptr + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_tag  <= '0;
            wb_data <= '0;
        end else if (start_wb) begin
            wb_tag  <= tag_q[repl_ptr];
            wb_data <= data_q[repl_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_done <= 1'b0;
            hit         <= 1'b0;
            hit_idx     <= '0;
            hit_data    <= '0;
            hit_dirty   <= 1'b0;
        end else begin
            lookup_done <= lookup_valid;
            hit         <= lookup_valid && lk_match;
            hit_idx     <= (lookup_valid && lk_match) ? lk_idx : '0;
            hit_data    <= (lookup_valid && lk_match) ? data_q[lk_idx] : '0;
            hit_dirty   <= lookup_valid && lk_match && dirty_q[lk_idx];
        end
    end

endmodule

// File: tb/tb_victim_buffer.sv
// tb/tb_victim_buffer.sv - randomized and directed self-checking bench for victim_buffer
module tb_victim_buffer;

    localparam int TAG_W   = 12;
    localparam int DATA_W  = 128;
    localparam int ENTRIES = 4;
    localparam int IDX_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lookup_valid;
    logic [TAG_W-1:0]  lookup_tag;
    logic              lookup_done;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [DATA_W-1:0] hit_data;
    logic              hit_dirty;
    logic              insert_valid;
    logic              insert_ready;
    logic [TAG_W-1:0]  insert_tag;
    logic [DATA_W-1:0] insert_data;
    logic              insert_dirty;
    logic              inv_valid;
    logic [IDX_W-1:0]  inv_idx;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;

    victim_buffer #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_done(lookup_done),
        .hit(hit), .hit_idx(hit_idx), .hit_data(hit_data), .hit_dirty(hit_dirty),
        .insert_valid(insert_valid), .insert_ready(insert_ready), .insert_tag(insert_tag),
        .insert_data(insert_data), .insert_dirty(insert_dirty),
        .inv_valid(inv_valid), .inv_idx(inv_idx),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          m_valid [ENTRIES];
    bit          m_dirty [ENTRIES];
    int          m_tag   [ENTRIES];
    bit [127:0]  m_data  [ENTRIES];
    int          m_ptr;
    bit          m_wb;
    int          m_wbtag;
    bit [127:0]  m_wbdata;
    bit          e_done, e_hit, e_dirty;
    int          e_idx;
    bit [127:0]  e_data;

    function automatic bit [127:0] mkdata(input int t);
        bit [15:0] h;
        h = 16'(t);
        return {8{h}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_data[i] = '0;
        end
        m_ptr = 0; m_wb = 0; m_wbtag = 0; m_wbdata = '0;
        e_done = 0; e_hit = 0; e_idx = 0; e_data = '0; e_dirty = 0;
    endtask

    task automatic model_step();
        bit nv [ENTRIES];
        bit nd [ENTRIES];
        bit accept, matched, freed;
        int t;
        e_done = lookup_valid; e_hit = 0; e_idx = 0; e_data = '0; e_dirty = 0;
        if (lookup_valid)
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_tag[i] == int'(lookup_tag)) begin
                    e_hit = 1; e_idx = i; e_data = m_data[i]; e_dirty = m_dirty[i];
                end
        accept = insert_valid && !m_wb;
        if (m_wb && wb_ready) m_wb = 0;
        matched = 0; freed = 0; t = m_ptr;
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_tag[i] == int'(insert_tag)) begin matched = 1; t = i; end
        if (!matched)
            for (int i = ENTRIES - 1; i >= 0; i--)
                if (!m_valid[i]) begin freed = 1; t = i; end
        for (int i = 0; i < ENTRIES; i++) begin nv[i] = m_valid[i]; nd[i] = m_dirty[i]; end
        if (inv_valid) begin nv[inv_idx] = 0; nd[inv_idx] = 0; end
        if (accept) begin
            nd[t] = matched ? (m_dirty[t] | insert_dirty) : insert_dirty;
            nv[t] = 1;
            if (!matched && !freed) begin
                if (m_valid[t] && m_dirty[t]) begin
                    m_wb = 1; m_wbtag = m_tag[t]; m_wbdata = m_data[t];
                end
                m_ptr = (m_ptr + 1) % ENTRIES;
            end
            m_tag[t]  = int'(insert_tag);
            m_data[t] = insert_data;
        end
        for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = nv[i]; m_dirty[i] = nd[i]; end
    endtask

    task automatic check_model();
        chk("lookup_done", lookup_done, e_done);
        chk("hit", hit, e_hit);
        chk("hit_idx", hit_idx, e_idx);
        chk("hit_data", hit_data, e_data);
        chk("hit_dirty", hit_dirty, e_dirty);
        chk("insert_ready", insert_ready, !m_wb);
        chk("wb_valid", wb_valid, m_wb);
        if (m_wb) begin
            chk("wb_tag", wb_tag, m_wbtag);
            chk("wb_data", wb_data, m_wbdata);
        end
    endtask

    task automatic idle();
        lookup_valid = 0; lookup_tag = '0; insert_valid = 0; insert_tag = '0;
        insert_data = '0; insert_dirty = 0; inv_valid = 0; inv_idx = '0; wb_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic ins(input int t, input bit d);
        insert_valid = 1; insert_tag = 12'(t); insert_data = mkdata(t); insert_dirty = d;
        step();
    endtask

    task automatic lk(input int t);
        lookup_valid = 1; lookup_tag = 12'(t);
        step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        do_reset();
        chk("reset insert_ready", insert_ready, 1'b1);
        chk("reset wb_valid", wb_valid, 1'b0);

        lk('h123);
        chk("first lookup_done", lookup_done, 1'b1);
        chk("first hit", hit, 1'b0);
        chk("first hit_idx", hit_idx, 2'd0);

        ins('h010, 0); ins('h011, 0); ins('h012, 0);
        lookup_valid = 1; lookup_tag = 12'h013;
        ins('h013, 0);
        chk("same-edge lookup miss", hit, 1'b0);
        lk('h012);
        chk("lookup 012 hit", hit, 1'b1);
        chk("lookup 012 idx", hit_idx, 2'd2);
        chk("lookup 012 data", hit_data, mkdata('h012));

        ins('h020, 0);
        chk("clean victim no wb", wb_valid, 1'b0);
        lk('h020);
        chk("020 in idx0", hit_idx, 2'd0);

        insert_valid = 1; insert_tag = 12'h011; insert_data = 128'hA11; insert_dirty = 1;
        step();
        lk('h011);
        chk("011 merged idx", hit_idx, 2'd1);
        chk("011 merged dirty", hit_dirty, 1'b1);

        ins('h030, 0);
        chk("wb starts", wb_valid, 1'b1);
        chk("wb_tag old idx1", wb_tag, 12'h011);
        chk("insert stalls", insert_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            lookup_valid = 1; lookup_tag = 12'h030;
            step();
            chk("wb_tag stable", wb_tag, 12'h011);
            chk("wb_data stable", wb_data, 128'hA11);
            chk("lookup in WB_WAIT", hit_idx, 2'd1);
        end
        wb_ready = 1;
        step();
        chk("wb done", wb_valid, 1'b0);
        chk("insert_ready back", insert_ready, 1'b1);

        inv_valid = 1; inv_idx = 2'd2;
        ins('h012, 1);
        lk('h012);
        chk("insert beats inv", hit, 1'b1);
        chk("insert beats inv dirty", hit_dirty, 1'b1);

        ins('h040, 0);
        chk("second wb", wb_valid, 1'b1);
        chk("second wb_tag", wb_tag, 12'h012);
        step();
        do_reset();
        chk("reset drops wb", wb_valid, 1'b0);
        lk('h040);
        chk("post-reset miss", hit, 1'b0);
        ins('h050, 0); ins('h051, 0); ins('h052, 0); ins('h053, 0); ins('h054, 0);
        lk('h054);
        chk("repl_ptr reset to 0", hit_idx, 2'd0);

        for (int c = 0; c < 2000; c++) begin
            if (c % 600 == 599) do_reset();
            lookup_valid = ($urandom_range(0, 1) == 1);
            lookup_tag   = 12'('h10 + $urandom_range(0, 7));
            insert_valid = ($urandom_range(0, 9) < 4);
            insert_tag   = 12'('h10 + $urandom_range(0, 7));
            insert_data  = {$urandom, $urandom, $urandom, $urandom};
            insert_dirty = ($urandom_range(0, 1) == 1);
            inv_valid    = ($urandom_range(0, 9) < 2);
            inv_idx      = 2'($urandom_range(0, 3));
            wb_ready     = ($urandom_range(0, 9) < 4);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
